// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver: frame-format enum,
// TX/RX state encodings and the baud divider calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Integer divide; callers keep the result at 4 or more so mid-bit sampling has room.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with registered read data, used to decouple the
// TX byte producer from the serialiser. DEPTH must be a power of two.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr;
    logic             rd;

    assign wr      = i_wr_en && !o_full;
    assign rd      = i_rd_en && !o_empty;
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count alone, so stale contents are never observable.
    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs regardless of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_rd_data <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr    <= rd_ptr + AW'(1);
                o_rd_data <= mem[rd_ptr];
            end
            case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// UART transceiver: FIFO-fed TX serialiser and error-checking RX deserialiser
// with a runtime internal loopback from the TX line into the RX synchroniser.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int      CLOCK_FREQUENCY = 12_000_000,
    parameter int      BAUD_RATE       = 115200,
    parameter int      DATA_BITS       = 8,
    parameter parity_e PARITY          = PARITY_NONE,
    parameter int      STOP_BITS       = 1,
    parameter int      TX_FIFO_DEPTH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_loopback,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx_busy,
    output logic                 o_uart_tx,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_en,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(STOP_CLKS + 1);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~(^d) : ^d;
    endfunction

    // ------------------------------------------------------------------ TX
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] tx_word;

    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
    logic                 tx_line_q, tx_line_d;

    assign fifo_wr = i_tx_valid && !fifo_full;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (fifo_wr),
        .i_wr_data (i_tx_data),
        .i_rd_en   (fifo_rd),
        .o_rd_data (tx_word),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_idx_d   = tx_idx_q;
        fifo_rd    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        tx_idx_d = tx_idx_q + IDX_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                // Chaining straight into START keeps queued words gap-free.
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_rd    = 1'b1;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // The line is registered from the next state so the pin never glitches.
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_word[tx_idx_d];
            TX_PARITY: tx_line_d = parity_of(tx_word);
            default:   tx_line_d = 1'b1;
        endcase
    end

    assign o_tx_ready = !fifo_full;
    assign o_tx_busy  = !fifo_empty || (tx_state_q != TX_IDLE);
    assign o_uart_tx  = i_loopback ? 1'b1 : tx_line_q;

    // ------------------------------------------------------------------ RX
    logic                 rx_line;
    logic                 rx_meta_q;
    logic                 rx_sync_q;
    logic                 rx_prev_q;

    rx_state_e            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_done;

    assign rx_line = i_loopback ? tx_line_q : i_uart_rx;

    // Both sources share the synchroniser so loopback timing matches the pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_line;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_idx_d   = '0;
                        rx_state_d = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_done    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_en         <= 1'b0;
            o_rx_data       <= '0;
            o_rx_parity_err <= 1'b0;
            o_rx_frame_err  <= 1'b0;
        end else begin
            o_rx_en <= rx_done;
            if (rx_done) begin
                o_rx_data       <= rx_shift_q;
                o_rx_parity_err <= (PARITY != PARITY_NONE) && (rx_par_q != parity_of(rx_shift_q));
                o_rx_frame_err  <= !rx_sync_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: three instances (8N1, 8E2, 7O1) at
// 12 clocks per bit, with hand-computed frames, latencies and strobe times.
module tb_uart_transceiver;
    import uart_pkg::*;

    localparam int CPB = 12;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       n_loopback, n_valid, n_ready, n_busy, n_uart_tx, n_rx, n_rx_en, n_perr, n_ferr;
    logic [7:0] n_data, n_rx_data;
    logic       e_loopback, e_valid, e_ready, e_busy, e_uart_tx, e_rx, e_rx_en, e_perr, e_ferr;
    logic [7:0] e_data, e_rx_data;
    logic       o_loopback, o_valid, o_ready, o_busy, o_uart_tx, o_rx, o_rx_en, o_perr, o_ferr;
    logic [6:0] o_data, o_rx_data;

    uart_transceiver #(
        .CLOCK_FREQUENCY (12_000_000), .BAUD_RATE (1_000_000), .DATA_BITS (8),
        .PARITY (PARITY_NONE), .STOP_BITS (1), .TX_FIFO_DEPTH (4)
    ) u_n (
        .i_clk (clk), .i_rst_n (rst_n), .i_loopback (n_loopback),
        .i_tx_valid (n_valid), .i_tx_data (n_data), .o_tx_ready (n_ready),
        .o_tx_busy (n_busy), .o_uart_tx (n_uart_tx), .i_uart_rx (n_rx),
        .o_rx_data (n_rx_data), .o_rx_en (n_rx_en),
        .o_rx_parity_err (n_perr), .o_rx_frame_err (n_ferr)
    );

    uart_transceiver #(
        .CLOCK_FREQUENCY (12_000_000), .BAUD_RATE (1_000_000), .DATA_BITS (8),
        .PARITY (PARITY_EVEN), .STOP_BITS (2), .TX_FIFO_DEPTH (4)
    ) u_e (
        .i_clk (clk), .i_rst_n (rst_n), .i_loopback (e_loopback),
        .i_tx_valid (e_valid), .i_tx_data (e_data), .o_tx_ready (e_ready),
        .o_tx_busy (e_busy), .o_uart_tx (e_uart_tx), .i_uart_rx (e_rx),
        .o_rx_data (e_rx_data), .o_rx_en (e_rx_en),
        .o_rx_parity_err (e_perr), .o_rx_frame_err (e_ferr)
    );

    uart_transceiver #(
        .CLOCK_FREQUENCY (12_000_000), .BAUD_RATE (1_000_000), .DATA_BITS (7),
        .PARITY (PARITY_ODD), .STOP_BITS (1), .TX_FIFO_DEPTH (2)
    ) u_o (
        .i_clk (clk), .i_rst_n (rst_n), .i_loopback (o_loopback),
        .i_tx_valid (o_valid), .i_tx_data (o_data), .o_tx_ready (o_ready),
        .o_tx_busy (o_busy), .o_uart_tx (o_uart_tx), .i_uart_rx (o_rx),
        .o_rx_data (o_rx_data), .o_rx_en (o_rx_en),
        .o_rx_parity_err (o_perr), .o_rx_frame_err (o_ferr)
    );

    // Strobe capture: {frame_err, parity_err, data}
    logic [9:0] n_q[$];
    logic [9:0] e_q[$];
    logic [9:0] o_q[$];
    int         e_t[$];
    int         n_pin_low = 0;
    int         e_pin_low = 0;

    always @(negedge clk) begin
        if (n_rx_en) n_q.push_back({n_ferr, n_perr, n_rx_data});
        if (e_rx_en) begin
            e_q.push_back({e_ferr, e_perr, e_rx_data});
            e_t.push_back(cyc);
        end
        if (o_rx_en) o_q.push_back({o_ferr, o_perr, 1'b0, o_rx_data});
        if (n_loopback && !n_uart_tx) n_pin_low++;
        if (e_loopback && !e_uart_tx) e_pin_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frame(input bit to_o, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (to_o) o_rx = bits[i];
            else      n_rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        if (to_o) o_rx = 1'b1;
        else      n_rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    logic [7:0]  burst [5];
    logic [9:0]  fr;
    logic [15:0] f;
    int          hs;
    int          m;
    int          guard;

    initial begin
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h81; burst[4] = 8'h3C;
        rst_n = 1'b0;
        n_loopback = 1'b0; n_valid = 1'b0; n_data = '0; n_rx = 1'b1;
        e_loopback = 1'b1; e_valid = 1'b0; e_data = '0; e_rx = 1'b1;
        o_loopback = 1'b0; o_valid = 1'b0; o_data = '0; o_rx = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_tx_pin", n_uart_tx, 1);
        check("rst_ready", n_ready, 1);
        check("rst_busy", n_busy, 0);
        check("rst_rx_en", n_rx_en, 0);
        check("rst_rx_data", n_rx_data, 0);
        check("rst_errs", {n_ferr, n_perr}, 0);
        check("rst_e_ready", e_ready, 1);
        check("rst_o_idle", {o_ready, o_busy, o_uart_tx}, 3'b101);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Latency and bit timing on the pin: start at N+2, each bit 12 cycles.
        hs = cyc;
        n_valid = 1'b1; n_data = 8'hA5;
        @(negedge clk);
        n_valid = 1'b0;
        check("lat_n1_high", n_uart_tx, 1);
        check("busy_after_hs", n_busy, 1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            m = 0;
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (n_uart_tx === fr[b]) m++;
            end
            check($sformatf("lat_bit%0d", b), m, CPB);
        end
        @(negedge clk);
        check("busy_after_stop", n_busy, 0);
        check("lat_end_cycle", cyc, hs + 122);

        // 8N1 loopback: one strobe with 0xA5, pin stays high.
        n_loopback = 1'b1; n_q.delete(); n_pin_low = 0;
        @(negedge clk);
        n_valid = 1'b1; n_data = 8'hA5;
        @(negedge clk);
        n_valid = 1'b0;
        repeat (200) @(negedge clk);
        check("lb_count", n_q.size(), 1);
        check("lb_word", (n_q.size() > 0) ? 32'(n_q[0]) : 32'hFFFF_FFFF, 10'h0A5);
        check("lb_pin_high", n_pin_low, 0);

        // 8E2 loopback burst through the FIFO.
        e_q.delete(); e_t.delete(); e_pin_low = 0;
        for (int i = 0; i < 5; i++) begin
            guard = 0;
            while (!e_ready && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            e_valid = 1'b1; e_data = burst[i];
            if (i == 0) hs = cyc;
            @(negedge clk);
        end
        e_valid = 1'b0;
        check("burst_ready_full", e_ready, 0);
        check("burst_busy", e_busy, 1);
        guard = 0;
        while (e_q.size() < 5 && guard < 1500) begin
            @(negedge clk);
            guard++;
        end
        check("burst_count", e_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_word%0d", i), (i < e_q.size()) ? 32'(e_q[i]) : 32'hFFFF_FFFF, {24'h0, burst[i]});
            check($sformatf("burst_time%0d", i), (i < e_t.size()) ? e_t[i] : -1, hs + 131 + 144 * i);
        end
        guard = 0;
        while (e_busy && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("burst_busy_fall", cyc, hs + 722);
        check("burst_ready_back", e_ready, 1);
        check("burst_pin_high", e_pin_low, 0);

        // 7O1 external RX: wrong parity flagged, then cleared by a good frame.
        o_q.delete();
        f = {6'b0, 1'b1, 1'b0, 7'h41, 1'b0};
        drive_frame(1'b1, f, 10);
        repeat (20) @(negedge clk);
        check("par_bad_count", o_q.size(), 1);
        check("par_bad_word", (o_q.size() > 0) ? 32'(o_q[0]) : 32'hFFFF_FFFF, 10'h141);
        f = {6'b0, 1'b1, 1'b0, 7'h2A, 1'b0};
        drive_frame(1'b1, f, 10);
        repeat (20) @(negedge clk);
        check("par_good_count", o_q.size(), 2);
        check("par_good_word", (o_q.size() > 1) ? 32'(o_q[1]) : 32'hFFFF_FFFF, 10'h02A);

        // 8N1 external RX: low stop bit, idle-line glitch, clean frame.
        n_loopback = 1'b0; n_q.delete();
        repeat (5) @(negedge clk);
        f = {6'b0, 1'b0, 8'h3C, 1'b0};
        drive_frame(1'b0, f, 10);
        repeat (20) @(negedge clk);
        check("ferr_count", n_q.size(), 1);
        check("ferr_word", (n_q.size() > 0) ? 32'(n_q[0]) : 32'hFFFF_FFFF, 10'h23C);
        n_rx = 1'b0;
        repeat (4) @(negedge clk);
        n_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_strobe", n_q.size(), 1);
        check("glitch_rx_idle", 32'(u_n.rx_state_q), 32'(RX_IDLE));
        f = {6'b0, 1'b1, 8'h96, 1'b0};
        drive_frame(1'b0, f, 10);
        repeat (20) @(negedge clk);
        check("clean_count", n_q.size(), 2);
        check("clean_word", (n_q.size() > 1) ? 32'(n_q[1]) : 32'hFFFF_FFFF, 10'h096);

        // Reset in the middle of TX 0xC3 (bit 2 is low at N+40).
        n_valid = 1'b1; n_data = 8'hC3;
        @(negedge clk);
        n_valid = 1'b0;
        repeat (39) @(negedge clk);
        check("mid_data_low", n_uart_tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_pin", n_uart_tx, 1);
        check("arst_ready", n_ready, 1);
        check("arst_busy", n_busy, 0);
        check("arst_rx_data", n_rx_data, 0);
        check("arst_rx_en", n_rx_en, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_loopback = 1'b1; n_q.delete();
        repeat (3) @(negedge clk);
        n_valid = 1'b1; n_data = 8'h5A;
        @(negedge clk);
        n_valid = 1'b0;
        repeat (200) @(negedge clk);
        check("post_rst_count", n_q.size(), 1);
        check("post_rst_word", (n_q.size() > 0) ? 32'(n_q[0]) : 32'hFFFF_FFFF, 10'h05A);
        check("post_rst_idle", n_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Parametrised UART transceiver: TX path with small input FIFO and RX path with error detection, both with configurable frame format. Runtime-selectable internal loopback routes the TX serialiser into the RX deserialiser, so loopback tests no longer need a separate wrapper. Sits between a byte-stream producer/consumer and the board UART pins.

Parameters:
CLOCK_FREQUENCY, 12_000_000, i_clk frequency in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer divide, must be >= 4)
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, PARITY_NONE, one of PARITY_NONE/PARITY_EVEN/PARITY_ODD (uart_pkg::parity_e)
STOP_BITS, 1, stop bits transmitted, 1 or 2
TX_FIFO_DEPTH, 4, TX FIFO entries, power of two >= 2

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_loopback  in  1  1: RX fed from internal TX line, o_uart_tx held high
i_tx_valid  in  1  TX word valid
i_tx_data  in  DATA_BITS  TX word
o_tx_ready  out  1  TX FIFO not full
o_tx_busy  out  1  FIFO non-empty or frame in flight
o_uart_tx  out  1  serial TX pin, idle high
i_uart_rx  in  1  serial RX pin, asynchronous
o_rx_data  out  DATA_BITS  received word
o_rx_en  out  1  one-cycle strobe, o_rx_data/error flags valid
o_rx_parity_err  out  1  parity mismatch, qualified by o_rx_en
o_rx_frame_err  out  1  first stop bit sampled low, qualified by o_rx_en

Behaviour:
- Reset: o_uart_tx=1, o_tx_ready=1, o_tx_busy=0, o_rx_en=0, o_rx_data=0, both err=0; FIFO emptied, both FSMs IDLE, counters 0. Reset mid-frame aborts immediately; line goes high asynchronously.
- TX handshake: word written when i_tx_valid && o_tx_ready; no write when full (data dropped only if producer ignores ready). Simultaneous write+pop when full is not allowed (ready=0); when empty, write then pop next cycle.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if NONE) -> STOP -> IDLE. Each bit held exactly CLKS_PER_BIT cycles. Data LSB first. STOP lasts STOP_BITS*CLKS_PER_BIT. Even parity: bit = XOR(data); odd: ~XOR(data).
- TX latency: with FSM idle and FIFO empty, handshake at cycle N -> start bit on internal line at N+2. Back-to-back FIFO words: next start bit immediately follows last stop bit, no idle gap.
- o_tx_busy: 1 from cycle after handshake until the last stop-bit cycle completes with FIFO empty.
- Loopback mux: rx_line = i_loopback ? tx_line : i_uart_rx. In loopback o_uart_tx=1. Changing i_loopback is permitted only with o_tx_busy=0 and RX idle; if changed mid-frame RX may flag errors but must return to IDLE within one frame time.
- RX sync: 2-flop synchroniser on i_uart_rx (loopback path also passes through it; constant 2-cycle delay).
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE. Falling edge in IDLE starts counter; sample at CLKS_PER_BIT/2; start sampled high -> glitch, back to IDLE, no strobe. Subsequent samples every CLKS_PER_BIT. Only first stop bit checked; STOP returns to IDLE right after the stop sample, so RX accepts frames with any stop count.
- o_rx_en: single-cycle pulse the cycle after the stop-bit sample; o_rx_data and err flags registered with it and held until the next strobe (err flags cleared on next strobe if good). Frame with error still strobes.
- No RX buffering: consumer must accept on strobe.

Decomposition:
- uart_pkg: parity_e enum, tx/rx state enums, function clks_per_bit(freq, baud).
- Sub-module uart_sync_fifo (parametrised width/depth, full/empty, registered read) for the TX FIFO; TX and RX FSMs stay in uart_transceiver.

Test Plan:
- 12 MHz, 1 Mbaud (12 clk/bit), 8N1, loopback=1: send 0xA5 -> o_rx_en once, o_rx_data=0xA5, errs 0; o_uart_tx stays 1.
- Loopback, 8E2, FIFO depth 4: burst 0x00,0xFF,0x55,0x81,0x3C with valid held -> ready drops while full, 5 strobes in order, no idle gap between TX frames, busy falls after last stop.
- loopback=0, 7O1: drive i_uart_rx with 0x41 and wrong parity -> o_rx_data=0x41, parity_err=1; next correct frame clears it.
- loopback=0: drive stop bit low for 0x3C -> frame_err=1, strobe; 4-cycle low glitch on idle line -> no strobe, FSM idle.
- Assert i_rst_n low mid-DATA of TX 0xC3 -> o_uart_tx=1 immediately, ready=1, busy=0; post-reset frame 0x5A received correctly.
- Measure latency: handshake at N with idle FSM -> tx_line low at N+2, each bit exactly 12 cycles.
